// File: rtl/fir_decimator.sv
// Decimating FIR low-pass with a serial multiply-accumulate datapath.
// Samples enter a shift-register history; every DECIM-th accepted sample
// starts a NUM_TAPS-cycle MAC pass. The result is then held on out_data
// until downstream takes it. Coefficients are writable only while idle.
module fir_decimator #(
    parameter int NUM_TAPS   = 32,
    parameter int DECIM      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    input  logic                          coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic signed [DATA_WIDTH-1:0]  coef_data,
    output logic                          coef_busy
);

    localparam int AW = $clog2(NUM_TAPS);
    localparam int TW = $clog2(NUM_TAPS + 1);
    localparam int CW = $clog2(DECIM + 1);
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    // Tap counter runs one past the last tap: the product pipeline needs a drain cycle.
    localparam logic [TW-1:0] TAP_END  = TW'(NUM_TAPS);
    localparam logic [CW-1:0] DC_LAST  = CW'(DECIM - 1);
    localparam logic [AW:0]   NT_EXT   = (AW + 1)'(NUM_TAPS);
    localparam logic signed [PW-1:0] DEQ_BIAS = (PW'(1) <<< BITS) - PW'(1);

    // Divide by 2^BITS rounding toward zero: negative values get a bias of
    // 2^BITS-1 before the arithmetic shift so they do not round toward -inf.
    function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] biased;
        logic signed [PW-1:0] shifted;
        if (p[PW-1]) begin
            biased = p + DEQ_BIAS;
        end else begin
            biased = p;
        end
        shifted = biased >>> BITS;
        return shifted[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]                    state_r;
    logic [CW-1:0]                 dcount_r;
    logic [TW-1:0]                 tap_r;
    logic signed [DATA_WIDTH-1:0]  acc_r;
    logic signed [DATA_WIDTH-1:0]  term_r;
    logic signed [DATA_WIDTH-1:0]  out_data_r;
    logic                          out_valid_r;
    logic                          in_ready_r;
    logic                          coef_busy_r;
    logic signed [DATA_WIDTH-1:0]  hist_r [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  coef_r [NUM_TAPS];

    logic                          in_xfer_s;
    logic                          addr_ok_s;
    logic [AW-1:0]                 tap_idx_s;
    logic signed [PW-1:0]          prod_s;
    logic signed [DATA_WIDTH-1:0]  term_next_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign coef_busy = coef_busy_r;

    // Handshake qualifiers, tap selection and the dequantized product for the current tap.
    always_comb begin
        in_xfer_s   = in_valid & in_ready_r;
        addr_ok_s   = ({1'b0, coef_addr} < NT_EXT);
        tap_idx_s   = (tap_r == TAP_END) ? '0 : tap_r[AW-1:0];
        prod_s      = PW'(coef_r[tap_idx_s]) * PW'(hist_r[tap_idx_s]);
        term_next_s = deq(prod_s);
    end

    // Sample history: shift on every accepted input, newest sample in slot 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                hist_r[k] <= '0;
            end
        end else if (in_xfer_s) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) begin
                hist_r[k] <= hist_r[k-1];
            end
            hist_r[0] <= in_data;
        end
    end

    // Coefficient bank: writes land only while idle, so a MAC pass sees a frozen bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_r[k] <= '0;
            end
        end else if (coef_wr_en && addr_ok_s && (state_r == ST_IDLE)) begin
            coef_r[coef_addr] <= coef_data;
        end
    end

    // Control FSM with decimation counter, pipelined MAC and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            dcount_r    <= '0;
            tap_r       <= '0;
            acc_r       <= '0;
            term_r      <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            coef_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_xfer_s) begin
                        if (dcount_r == DC_LAST) begin
                            dcount_r    <= '0;
                            tap_r       <= '0;
                            state_r     <= ST_COMPUTE;
                            in_ready_r  <= 1'b0;
                            coef_busy_r <= 1'b1;
                        end else begin
                            dcount_r <= dcount_r + CW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    // term_r holds the previous tap's product; acc lags it by one cycle.
                    term_r <= term_next_s;
                    acc_r  <= (tap_r == '0) ? '0 : acc_r + term_r;
                    if (tap_r == TAP_END) begin
                        out_data_r  <= acc_r + term_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUTPUT;
                    end else begin
                        tap_r <= tap_r + TW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        coef_busy_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    coef_busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: directed vectors push hand-computed
// results into a queue, a negedge monitor pops on every output transfer.
module tb_fir_decimator;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic               coef_wr_en;
    logic [4:0]         coef_addr;
    logic signed [31:0] coef_data;
    logic               coef_busy;

    int     n_cmp;
    int     n_bad;
    int     n_out;
    longint exp_q [$];

    fir_decimator #(
        .NUM_TAPS(32), .DECIM(8), .DATA_WIDTH(32), .BITS(10)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_busy(coef_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: every output transfer pops one expected value.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %0d, required no output", out_data);
            end else begin
                check("out_data", longint'(out_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic signed [31:0] d);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && w < 300) begin
            @(posedge clock); #1;
            w++;
        end
        if (!in_ready) begin
            fail_now("send_wait");
            in_valid = 1'b0;
        end else begin
            @(posedge clock); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_n(input int n, input logic signed [31:0] d);
        for (int i = 0; i < n; i++) send(d);
    endtask

    task automatic wcoef(input logic [4:0] a, input logic signed [31:0] d);
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_data  = d;
        @(posedge clock); #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!in_ready && w < 300) begin
            @(posedge clock); #1;
            w++;
        end
        if (!in_ready) fail_now(name);
    endtask

    task automatic wait_valid(input string name, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 300) begin
            @(posedge clock); #1;
            cycles++;
        end
        if (!out_valid) fail_now(name);
    endtask

    initial begin
        int lat;
        int w;
        bit stall_ok_data;
        bit stall_ok_ready;
        n_cmp = 0; n_bad = 0; n_out = 0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_wr_en = 1'b0; coef_addr = '0; coef_data = '0;
        #23;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_coef_busy", longint'(coef_busy), 0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;

        // 1 impulse through a ramp filter lands on tap 7
        for (int k = 0; k < 32; k++) wcoef(5'(k), 32'(signed'((k + 1) * 1024)));
        exp_q.push_back(8192);
        send(1024);
        send_n(7, 0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (out_valid && lat == 0) lat = i;
        end
        check("impulse_latency", lat, 33);
        check("busy_after_out", longint'(coef_busy), 0);

        // 2 decimation count
        for (int k = 1; k < 32; k++) wcoef(5'(k), 0);
        wcoef(0, 1024);
        repeat (3) exp_q.push_back(1024);
        send_n(7, 1024);
        repeat (40) @(posedge clock);
        #1;
        check("no_early_out", n_out, 1);
        send_n(17, 1024);

        // 3 truncation toward zero
        wait_ready("t3_ready");
        wcoef(0, 1);
        exp_q.push_back(0);
        send_n(8, -1);
        wait_ready("t3_ready2");
        wcoef(0, -1536);
        exp_q.push_back(-1);
        send_n(8, 1);
        exp_q.push_back(-1536);
        send_n(8, 1024);

        // 4 backpressure, with a sample held on the input during the stall
        wait_ready("t4_ready");
        wcoef(0, 3072);
        wcoef(7, 1024);
        out_ready = 1'b0;
        exp_q.push_back(4096);
        exp_q.push_back(2048);
        send_n(8, 1024);
        wait_valid("t4_valid", w);
        in_valid = 1'b1;
        in_data  = 2048;
        stall_ok_data  = 1'b1;
        stall_ok_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_data !== 32'sd4096 || out_valid !== 1'b1) stall_ok_data = 1'b0;
            if (in_ready !== 1'b0) stall_ok_ready = 1'b0;
            @(posedge clock); #1;
        end
        check("stall_out_stable", longint'(stall_ok_data), 1);
        check("stall_in_ready_low", longint'(stall_ok_ready), 1);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("ready_after_release", longint'(in_ready), 1);
        send(2048);
        send_n(7, 0);

        // 5 writes while busy are ignored; idle and concurrent writes apply
        wait_ready("t5_ready");
        wcoef(7, 0);
        wcoef(0, 1024);
        exp_q.push_back(512);
        send_n(8, 512);
        check("busy_in_compute", longint'(coef_busy), 1);
        wcoef(0, 4096);
        wait_ready("t5_ready2");
        out_ready = 1'b0;
        exp_q.push_back(512);
        send_n(8, 512);
        wait_valid("t5_valid", w);
        wcoef(0, 4096);
        check("busy_in_output", longint'(coef_busy), 1);
        out_ready = 1'b1;
        exp_q.push_back(512);
        send_n(8, 512);
        wait_ready("t5_ready3");
        wcoef(0, 4096);
        exp_q.push_back(2048);
        send_n(8, 512);
        wait_ready("t5_ready4");
        exp_q.push_back(1024);
        send_n(7, 512);
        coef_wr_en = 1'b1;
        coef_addr  = 0;
        coef_data  = 2048;
        send(512);
        coef_wr_en = 1'b0;

        // 6 reset in the middle of a MAC pass
        wait_ready("t6_ready");
        send_n(8, 4096);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        check("midrst_coef_busy", longint'(coef_busy), 0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        for (int k = 0; k < 32; k++) wcoef(5'(k), 1024);
        exp_q.push_back(8192);
        send_n(8, 1024);

        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clock); #1;
            w++;
        end
        check("queue_drained", exp_q.size(), 0);
        check("outputs_total", n_out, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
